// File: rtl/pid_master_pkg.sv
// ============================================================================
// Module : pid_master_pkg
// Brief  : Shared register addresses and FSM state encoding for the PID master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pid_master_pkg;

    localparam logic [3:0] ADDR_RESULT = 4'd0;
    localparam logic [3:0] ADDR_SP     = 4'd4;
    localparam logic [3:0] ADDR_PV     = 4'd5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_SP  = 3'd1,
        WR_PV  = 3'd2,
        SETTLE = 3'd3,
        RD_RES = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pid_master_watchdog.sv
// ============================================================================
// Module : pid_master_watchdog
// Brief  : Counts consecutive stalled bus cycles; pulses expire on the last one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pid_master_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign expire = stall && (r_cnt == c_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!stall || expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pid_avalon_master.sv
// ============================================================================
// Module : pid_avalon_master
// Brief  : Avalon-MM master running one SP/PV write + RESULT read per sample.
//          Optional bus timeout enabled by defining PID_MASTER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pid_avalon_master
    import pid_master_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 2
`ifdef PID_MASTER_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] sp_in,
    input  logic [31:0] pv_in,
    input  logic        pv_valid,
    output logic [3:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] result_out,
    output logic        result_valid,
    output logic        busy,
    output logic [15:0] overrun_count,
    output logic        timeout_err
);

    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic [31:0] r_sp, r_pv, r_pend_sp, r_pend_pv, r_sp_shadow;
    logic        r_pend_valid, r_sp_dirty;
    logic [7:0]  r_settle_cnt;
    logic [31:0] r_result;
    logic        r_result_valid;
    logic [15:0] r_overrun;
    logic        w_start, w_expire;
    logic [31:0] w_start_sp, w_start_pv;

    // A fresh strobe in IDLE supersedes any pending sample.
    assign w_start    = (r_state == IDLE) && (pv_valid || r_pend_valid);
    assign w_start_sp = pv_valid ? sp_in : r_pend_sp;
    assign w_start_pv = pv_valid ? pv_in : r_pend_pv;

    assign busy          = (r_state != IDLE);
    assign result_out    = r_result;
    assign result_valid  = r_result_valid;
    assign overrun_count = r_overrun;

`ifdef PID_MASTER_TIMEOUT_EN
    logic r_timeout_err;

    pid_master_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .stall  ((avm_write || avm_read) && avm_waitrequest),
        .expire (w_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_expire) begin
            r_timeout_err <= 1'b1;
        end else if (r_state == DONE) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        avm_address   = 4'd0;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;
        avm_read      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = ((w_start_sp != r_sp_shadow) || r_sp_dirty) ? WR_SP : WR_PV;
                end
            end
            WR_SP: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_SP;
                avm_writedata = r_sp;
                if (!avm_waitrequest) w_state_next = WR_PV;
            end
            WR_PV: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_PV;
                avm_writedata = r_pv;
                if (!avm_waitrequest) w_state_next = SETTLE;
            end
            SETTLE: begin
                if (r_settle_cnt == c_settle_last) w_state_next = RD_RES;
            end
            RD_RES: begin
                avm_read    = 1'b1;
                avm_address = ADDR_RESULT;
                if (!avm_waitrequest) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_expire) w_state_next = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sp           <= 32'd0;
            r_pv           <= 32'd0;
            r_pend_sp      <= 32'd0;
            r_pend_pv      <= 32'd0;
            r_pend_valid   <= 1'b0;
            r_sp_shadow    <= 32'd0;
            r_sp_dirty     <= 1'b1;
            r_settle_cnt   <= 8'd0;
            r_result       <= 32'd0;
            r_result_valid <= 1'b0;
            r_overrun      <= 16'd0;
        end else begin
            if (w_start) begin
                r_sp         <= w_start_sp;
                r_pv         <= w_start_pv;
                r_pend_valid <= 1'b0;
            end
            // Strobes while busy park in a single slot; only those outside DONE are overruns.
            if (pv_valid && (r_state != IDLE)) begin
                r_pend_sp    <= sp_in;
                r_pend_pv    <= pv_in;
                r_pend_valid <= 1'b1;
                if ((r_state != DONE) && (r_overrun != 16'hFFFF)) begin
                    r_overrun <= r_overrun + 16'd1;
                end
            end
            if ((r_state == WR_SP) && !avm_waitrequest) begin
                r_sp_shadow <= r_sp;
                r_sp_dirty  <= 1'b0;
            end
            if (w_expire) r_sp_dirty <= 1'b1;
            r_settle_cnt <= (r_state == SETTLE) ? r_settle_cnt + 8'd1 : 8'd0;
            if ((r_state == RD_RES) && !avm_waitrequest) begin
                r_result       <= avm_readdata;
                r_result_valid <= 1'b1;
            end else begin
                r_result_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pid_avalon_master.sv
// ============================================================================
// Module : tb_pid_avalon_master
// Brief  : Directed bench with a behavioural PID slave (Kp=1, limits +/-4000).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pid_avalon_master;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] sp_in, pv_in;
    logic        pv_valid;
    logic [3:0]  avm_address;
    logic        avm_write, avm_read;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] result_out;
    logic        result_valid, busy, timeout_err;
    logic [15:0] overrun_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pid_avalon_master #(
        .SETTLE_CYCLES (2)
`ifdef PID_MASTER_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .sp_in           (sp_in),
        .pv_in           (pv_in),
        .pv_valid        (pv_valid),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .result_out      (result_out),
        .result_valid    (result_valid),
        .busy            (busy),
        .overrun_count   (overrun_count),
        .timeout_err     (timeout_err)
    );

    // Behavioural slave: stores SP/PV, returns clamp(SP - PV) on address 0.
    logic signed [31:0] s_sp = 0, s_pv = 0;
    int sp_writes = 0, pv_writes = 0;

    function automatic logic [31:0] clamp(input logic signed [31:0] d);
        if (d > 32'sd4000)       return 32'sd4000;
        else if (d < -32'sd4000) return -32'sd4000;
        else                     return d;
    endfunction

    assign avm_readdata = (avm_address == 4'd0) ? clamp(s_sp - s_pv) : 32'd0;

    always @(posedge clock) begin
        if (avm_write && !avm_waitrequest) begin
            if (avm_address == 4'd4) begin
                s_sp      <= avm_writedata;
                sp_writes <= sp_writes + 1;
            end else if (avm_address == 4'd5) begin
                s_pv      <= avm_writedata;
                pv_writes <= pv_writes + 1;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] sp, input logic [31:0] pv);
        sp_in    = sp;
        pv_in    = pv;
        pv_valid = 1'b1;
        @(negedge clock);
        pv_valid = 1'b0;
    endtask

    // lat counts negedges since the strobe was driven; start is the current count.
    task automatic wait_result(input int start, output int lat);
        bit ok = 1'b0;
        lat = start;
        for (int i = 0; i < 60 && !ok; i++) begin
            check_value("rw_excl", {31'd0, avm_read & avm_write}, 32'd0);
            if (result_valid) ok = 1'b1;
            else begin
                @(negedge clock);
                lat++;
            end
        end
        if (!ok) check_value("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [31:0] sp, input logic [31:0] pv,
                           input logic [31:0] exp_res, input int exp_lat);
        int lat;
        send(sp, pv);
        wait_result(1, lat);
        check_value({tag, "_result"}, result_out, exp_res);
        check_value({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clock);
        check_value({tag, "_strobe_len"}, {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        int lat, base_sp, base_pv, k;
        bit seen;
        reset = 1'b1;
        sp_in = 32'd0;
        pv_in = 32'd0;
        pv_valid = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (3) @(negedge clock);
        check_value("rst_cmd", {26'd0, avm_read, avm_write, avm_address}, 32'd0);
        check_value("rst_wdata", avm_writedata, 32'd0);
        check_value("rst_result", result_out, 32'd0);
        check_value("rst_flags", {29'd0, result_valid, busy, timeout_err}, 32'd0);
        check_value("rst_overrun", {16'd0, overrun_count}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // First sample: SP shadow dirty, so both writes occur.
        run_one("t1", 32'd100, 32'd40, 32'd60, 6);
        check_value("t1_sp_writes", 32'(sp_writes), 32'd1);
        check_value("t1_pv_writes", 32'(pv_writes), 32'd1);
        check_value("t1_slave_sp", s_sp, 32'd100);

        // Unchanged SP: no address-4 write, one cycle shorter.
        run_one("t2", 32'd100, 32'd90, 32'd10, 5);
        check_value("t2_sp_writes", 32'(sp_writes), 32'd1);

        run_one("t3a", 32'd10000, 32'd0, 32'd4000, 6);
        run_one("t3b", -32'sd10000, 32'd0, -32'sd4000, 6);

        // Stall WR_PV for 5 cycles.
        base_pv = pv_writes;
        avm_waitrequest = 1'b1;
        send(-32'sd10000, -32'sd10300);
        for (int i = 0; i < 5; i++) begin
            check_value("t4_stall_ctl", {26'd0, avm_read, avm_write, avm_address}, 32'h15);
            check_value("t4_stall_data", avm_writedata, -32'sd10300);
            @(negedge clock);
        end
        avm_waitrequest = 1'b0;
        wait_result(6, lat);
        check_value("t4_result", result_out, 32'd300);
        check_value("t4_latency", 32'(lat), 32'd10);
        check_value("t4_pv_writes", 32'(pv_writes - base_pv), 32'd1);
        @(negedge clock);

        // Three strobes while busy: only the last one is processed afterwards.
        base_sp = sp_writes;
        send(32'd200, 32'd0);
        sp_in = 32'd200; pv_valid = 1'b1;
        pv_in = 32'd50;  @(negedge clock);
        pv_in = 32'd70;  @(negedge clock);
        pv_in = 32'd123; @(negedge clock);
        pv_valid = 1'b0;
        wait_result(4, lat);
        check_value("t5_first_result", result_out, 32'd200);
        check_value("t5_overrun", {16'd0, overrun_count}, 32'd3);
        @(negedge clock);
        wait_result(1, lat);
        check_value("t5_pending_result", result_out, 32'd77);
        check_value("t5_sp_writes", 32'(sp_writes - base_sp), 32'd1);
        repeat (3) @(negedge clock);
        check_value("t5_idle", {30'd0, busy, result_valid}, 32'd0);
        check_value("t5_overrun_hold", {16'd0, overrun_count}, 32'd3);

`ifdef PID_MASTER_TIMEOUT_EN
        // Stuck waitrequest: command held 16 cycles, then abort.
        avm_waitrequest = 1'b1;
        send(32'd5, 32'd1);
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && avm_write; i++) begin
            k++;
            seen |= result_valid;
            @(negedge clock);
        end
        check_value("t6_cmd_cycles", 32'(k), 32'd16);
        check_value("t6_after", {28'd0, avm_write, busy, timeout_err, seen}, 32'h2);
        avm_waitrequest = 1'b0;
        run_one("t6b", 32'd5, 32'd2, 32'd3, 6);
        check_value("t6_err_cleared", {31'd0, timeout_err}, 32'd0);
`else
        check_value("t6_no_timeout", {31'd0, timeout_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
